// File: rtl/multitap_delay.sv
// Multi-tap echo/delay line: circular sample history with per-tap runtime delay
// and a saturated dry-plus-taps echo mix, all advanced by a sample strobe.
module multitap_delay #(
    parameter int A_WIDTH  = 9,
    parameter int D_WIDTH  = 8,
    parameter int NUM_TAPS = 2,
    parameter int G_WIDTH  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         sample_en,
    input  logic [D_WIDTH-1:0]           din,
    input  logic [NUM_TAPS*A_WIDTH-1:0]  delay,
    input  logic [NUM_TAPS*G_WIDTH-1:0]  gain_shift,
    output logic [NUM_TAPS*D_WIDTH-1:0]  tap_out,
    output logic [D_WIDTH-1:0]           mix_out,
    output logic                         out_valid,
    output logic                         primed
);

    localparam int DEPTH   = 2 ** A_WIDTH;
    localparam int E_WIDTH = D_WIDTH + $clog2(NUM_TAPS + 1);
    localparam logic [A_WIDTH:0] FILL_FULL = {1'b1, {A_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    logic [D_WIDTH-1:0]          r_mem [DEPTH];
    logic [A_WIDTH-1:0]          r_wr_ptr;
    logic [A_WIDTH:0]            r_fill_cnt;
    logic [A_WIDTH:0]            w_fill_nxt;
    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [NUM_TAPS*D_WIDTH-1:0] r_tap;
    logic [D_WIDTH-1:0]          r_mix;
    logic                        r_valid;
    logic [NUM_TAPS*D_WIDTH-1:0] w_tap;
    logic signed [E_WIDTH-1:0]   w_sum;
    logic [D_WIDTH-1:0]          w_mix;
    logic                        w_accept;

    function automatic logic signed [E_WIDTH-1:0] sext(input logic [D_WIDTH-1:0] v);
        return $signed({{(E_WIDTH-D_WIDTH){v[D_WIDTH-1]}}, v});
    endfunction

    assign w_accept   = sample_en & ~clear;
    assign w_fill_nxt = (r_fill_cnt == FILL_FULL) ? r_fill_cnt : r_fill_cnt + {{A_WIDTH{1'b0}}, 1'b1};

    // Per-tap read: bypass at zero delay, zero while the history is still unwritten.
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        logic [A_WIDTH-1:0] w_d;
        logic [A_WIDTH-1:0] w_rd_addr;
        assign w_d       = delay[k*A_WIDTH +: A_WIDTH];
        assign w_rd_addr = r_wr_ptr - w_d;
        assign w_tap[k*D_WIDTH +: D_WIDTH] =
            (w_d == {A_WIDTH{1'b0}})      ? din :
            (r_fill_cnt < {1'b0, w_d})    ? {D_WIDTH{1'b0}} :
                                            r_mem[w_rd_addr];
    end

    // Echo mix: widened sum of dry input and attenuated taps, then saturated.
    always_comb begin
        w_sum = sext(din);
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_sum = w_sum + (sext(w_tap[k*D_WIDTH +: D_WIDTH]) >>> gain_shift[k*G_WIDTH +: G_WIDTH]);
        end
        if (w_sum[E_WIDTH-1:D_WIDTH-1] == {(E_WIDTH-D_WIDTH+1){w_sum[E_WIDTH-1]}}) begin
            w_mix = w_sum[D_WIDTH-1:0];
        end else if (w_sum[E_WIDTH-1]) begin
            w_mix = {1'b1, {(D_WIDTH-1){1'b0}}};
        end else begin
            w_mix = {1'b0, {(D_WIDTH-1){1'b1}}};
        end
    end

    // Next-state logic for the fill tracking FSM.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, FILL: begin
                    if (sample_en) begin
                        w_state_nxt = (w_fill_nxt == FILL_FULL) ? RUN : FILL;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                RUN:     w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointer, fill count and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= {A_WIDTH{1'b0}};
            r_fill_cnt <= {(A_WIDTH+1){1'b0}};
            r_tap      <= {(NUM_TAPS*D_WIDTH){1'b0}};
            r_mix      <= {D_WIDTH{1'b0}};
            r_valid    <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= {A_WIDTH{1'b0}};
            r_fill_cnt <= {(A_WIDTH+1){1'b0}};
            r_tap      <= {(NUM_TAPS*D_WIDTH){1'b0}};
            r_mix      <= {D_WIDTH{1'b0}};
            r_valid    <= 1'b0;
        end else if (sample_en) begin
            r_wr_ptr   <= r_wr_ptr + {{(A_WIDTH-1){1'b0}}, 1'b1};
            r_fill_cnt <= w_fill_nxt;
            r_tap      <= w_tap;
            r_mix      <= w_mix;
            r_valid    <= 1'b1;
        end else begin
            r_valid    <= 1'b0;
        end
    end

    // History RAM; left uninitialised because the fill count masks stale entries.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign tap_out   = r_tap;
    assign mix_out   = r_mix;
    assign out_valid = r_valid;
    assign primed    = (r_state == RUN);

endmodule

// File: tb/tb_multitap_delay.sv
// Directed bench for multitap_delay at A_WIDTH=4, D_WIDTH=8, NUM_TAPS=2, G_WIDTH=3.
module tb_multitap_delay;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        sample_en;
    logic [7:0]  din;
    logic [7:0]  delay;
    logic [5:0]  gain_shift;
    logic [15:0] tap_out;
    logic [7:0]  mix_out;
    logic        out_valid;
    logic        primed;

    int n_total;
    int n_bad;

    multitap_delay #(.A_WIDTH(4), .D_WIDTH(8), .NUM_TAPS(2), .G_WIDTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .sample_en  (sample_en),
        .din        (din),
        .delay      (delay),
        .gain_shift (gain_shift),
        .tap_out    (tap_out),
        .mix_out    (mix_out),
        .out_valid  (out_valid),
        .primed     (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_sample(input logic [7:0] d);
        sample_en = 1'b1;
        din       = d;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({tap_out, mix_out, out_valid, primed} !== 26'd0) begin
            n_bad++;
            $display("FAIL reset: got tap=%h mix=%h v=%b p=%b, want all 0", tap_out, mix_out, out_valid, primed);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ramp();
        logic [7:0] exp0;
        delay      = {4'd0, 4'd3};
        gain_shift = 6'd0;
        for (int i = 1; i <= 8; i++) begin
            exp0 = (i > 3) ? 8'(i - 3) : 8'd0;
            do_sample(8'(i));
            n_total++;
            if (tap_out[7:0] !== exp0 || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL ramp s%0d: got tap0=%0d v=%b, want tap0=%0d v=1", i, tap_out[7:0], out_valid, exp0);
            end
            repeat (2) begin
                @(posedge clk);
                #1;
                n_total++;
                if (tap_out[7:0] !== exp0 || out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ramp_hold s%0d: got tap0=%0d v=%b, want tap0=%0d v=0", i, tap_out[7:0], out_valid, exp0);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp1;
        logic [7:0] expm;
        logic       expp;
        do_clear();
        delay      = {4'd15, 4'd0};
        gain_shift = 6'd0;
        for (int i = 1; i <= 40; i++) begin
            exp1 = (i > 15) ? 8'(i - 15) : 8'd0;
            expm = 8'(2 * i) + exp1;
            expp = (i >= 16);
            do_sample(8'(i));
            n_total++;
            if (tap_out !== {exp1, 8'(i)} || mix_out !== expm || primed !== expp) begin
                n_bad++;
                $display("FAIL wrap s%0d: got tap1=%0d tap0=%0d mix=%0d p=%b, want %0d %0d %0d %b",
                         i, tap_out[15:8], tap_out[7:0], mix_out, primed, exp1, i, expm, expp);
            end
        end
    endtask

    task automatic test_mix();
        logic [7:0] dins [6];
        logic [5:0] shs  [6];
        logic [7:0] exps [6];
        dins = '{8'd100, 8'h9C, 8'hF8, 8'd40, 8'd127, 8'h80};
        shs  = '{6'o00,  6'o00, 6'o20, 6'o21, 6'o77,  6'o77};
        exps = '{8'd127, 8'h80, 8'hEE, 8'd70, 8'd127, 8'h80};
        delay = 8'd0;
        for (int i = 0; i < 6; i++) begin
            gain_shift = shs[i];
            do_sample(dins[i]);
            n_total++;
            if (mix_out !== exps[i] || tap_out !== {dins[i], dins[i]}) begin
                n_bad++;
                $display("FAIL mix v%0d: got mix=%h tap=%h, want mix=%h tap=%h", i, mix_out, tap_out, exps[i], {dins[i], dins[i]});
            end
        end
    endtask

    task automatic test_delay_change();
        logic [7:0] exp0;
        do_clear();
        delay      = {4'd0, 4'd3};
        gain_shift = 6'd0;
        for (int i = 1; i <= 22; i++) begin
            if (i == 20) delay = {4'd0, 4'd7};
            exp0 = (i >= 20) ? 8'(i - 7) : ((i > 3) ? 8'(i - 3) : 8'd0);
            do_sample(8'(i));
            if (i >= 17) begin
                n_total++;
                if (tap_out[7:0] !== exp0) begin
                    n_bad++;
                    $display("FAIL delay_change s%0d: got tap0=%h, want %h", i, tap_out[7:0], exp0);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] exp0;
        n_total++;
        if (primed !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_primed: got %b, want 1", primed);
        end
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if ({tap_out, mix_out, out_valid, primed} !== 26'd0) begin
            n_bad++;
            $display("FAIL async_reset: got tap=%h mix=%h v=%b p=%b, want all 0", tap_out, mix_out, out_valid, primed);
        end
        #2;
        rst   = 1'b1;
        delay = {4'd0, 4'd2};
        for (int i = 1; i <= 4; i++) begin
            exp0 = (i > 2) ? 8'(i - 2) : 8'd0;
            do_sample(8'(i));
            n_total++;
            if (tap_out[7:0] !== exp0) begin
                n_bad++;
                $display("FAIL post_reset s%0d: got tap0=%0d, want %0d", i, tap_out[7:0], exp0);
            end
        end
    endtask

    task automatic test_clear_collision();
        logic [7:0] exp0 [3];
        logic [7:0] exp1 [3];
        logic [7:0] expm [3];
        exp0 = '{8'd0, 8'd0,  8'd50};
        exp1 = '{8'd0, 8'd50, 8'd51};
        expm = '{8'd50, 8'd101, 8'd127};
        do_clear();
        delay      = {4'd1, 4'd2};
        gain_shift = 6'd0;
        for (int i = 1; i <= 17; i++) do_sample(8'(i));
        n_total++;
        if (primed !== 1'b1) begin
            n_bad++;
            $display("FAIL collide_pre_primed: got %b, want 1", primed);
        end
        clear     = 1'b1;
        sample_en = 1'b1;
        din       = 8'd99;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        sample_en = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || primed !== 1'b0 || tap_out !== 16'd0 || mix_out !== 8'd0) begin
            n_bad++;
            $display("FAIL collide: got v=%b p=%b tap=%h mix=%h, want 0 0 0000 00", out_valid, primed, tap_out, mix_out);
        end
        for (int i = 0; i < 3; i++) begin
            do_sample(8'(50 + i));
            n_total++;
            if (tap_out !== {exp1[i], exp0[i]} || mix_out !== expm[i] || primed !== 1'b0) begin
                n_bad++;
                $display("FAIL after_collide s%0d: got tap=%h mix=%0d p=%b, want tap=%h mix=%0d p=0",
                         i + 1, tap_out, mix_out, primed, {exp1[i], exp0[i]}, expm[i]);
            end
        end
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        rst        = 1'b0;
        clear      = 1'b0;
        sample_en  = 1'b0;
        din        = 8'd0;
        delay      = 8'd0;
        gain_shift = 6'd0;
        test_reset();
        test_ramp();
        test_wrap();
        test_mix();
        test_delay_change();
        test_async_reset();
        test_clear_collision();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
